// File: rtl/qam_destreamer.sv
// qam_destreamer: packs 4-bit QAM symbols into 16-bit words, buffers them, and streams whole packets low byte first.
// Optional QAM_SYMBOL_TIMEOUT_EN drops a partial word after TIMEOUT_CYCLES without a symbol.
package qam_destreamer_pkg;
   typedef struct packed {
      logic [7:0] Source;
      logic [7:0] Destination;
      logic [7:0] Length;
      logic [7:0] Data;
      logic       SoP;
      logic       EoP;
      logic       Valid;
   } UART_PACKET;
endpackage

module qam_destreamer
   import qam_destreamer_pkg::*;
#(
   parameter logic [7:0] SRC_ADDR         = 8'h10,
   parameter logic [7:0] DEST_ADDR        = 8'h00,
   parameter int         WORDS_PER_PACKET = 4,
   parameter int         FIFO_DEPTH       = 16,
   parameter int         TIMEOUT_CYCLES   = 2123142
) (
   input  logic                          ipClk,
   input  logic                          ipReset,
   input  logic [3:0]                    ipQAMBlock,
   input  logic                          ipQAMBlockValid,
   output UART_PACKET                    opTxStream,
   input  logic                          ipTxReady,
   output logic [$clog2(FIFO_DEPTH):0]   opFIFO_Size,
   output logic                          opOverflow
);
   localparam int             AW        = $clog2(FIFO_DEPTH);
   localparam int             CW        = AW + 1;
   localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]  PKT_CNT   = CW'(WORDS_PER_PACKET);
   localparam logic [6:0]     LAST_IDX  = 7'(WORDS_PER_PACKET - 1);
   localparam logic [7:0]     LEN_BYTES = 8'(2 * WORDS_PER_PACKET);

   if (WORDS_PER_PACKET < 1 || WORDS_PER_PACKET > 127 || FIFO_DEPTH < WORDS_PER_PACKET ||
       (1 << AW) != FIFO_DEPTH || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("qam_destreamer: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   logic [1:0]    nib_q, nib_d;
   logic [11:0]   part_q, part_d;
   logic          push_q, push_d;
   logic [15:0]   push_word_q, push_word_d;

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          full, pop, wr_en;

   state_t        state_q, state_d;
   logic [6:0]    widx_q, widx_d;
   logic [15:0]   hold_q, hold_d;
   logic          last;

`ifdef QAM_SYMBOL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;

   assign tmo_hit = (nib_q != 2'd0) && (tmo_q == TW'(TIMEOUT_CYCLES));

   always_comb begin
      tmo_d = tmo_q + TW'(1);
      if (ipQAMBlockValid || nib_q == 2'd0 || tmo_hit) tmo_d = '0;
   end

   always_ff @(posedge ipClk) begin
      if (!ipReset) tmo_q <= '0;
      else          tmo_q <= tmo_d;
   end
`endif

   // The fourth nibble completes the word directly; it is registered for a one-cycle push.
   always_comb begin
      nib_d       = nib_q;
      part_d      = part_q;
      push_d      = 1'b0;
      push_word_d = push_word_q;
      if (ipQAMBlockValid) begin
         nib_d = nib_q + 2'd1;
         if (nib_q == 2'd3) begin
            push_d      = 1'b1;
            push_word_d = {ipQAMBlock, part_q};
         end else begin
            part_d[{nib_q, 2'b00} +: 4] = ipQAMBlock;
         end
      end
`ifdef QAM_SYMBOL_TIMEOUT_EN
      else if (tmo_hit) begin
         nib_d = 2'd0;
      end
`endif
   end

   assign last = (widx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      widx_d  = widx_q;
      hold_d  = hold_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (count_q >= PKT_CNT) begin
               pop     = 1'b1;
               hold_d  = mem_q[rd_ptr_q];
               widx_d  = '0;
               state_d = LOW;
            end
         end
         LOW: begin
            if (ipTxReady) state_d = HIGH;
         end
         HIGH: begin
            if (ipTxReady) begin
               if (last) begin
                  state_d = IDLE;
               end else begin
                  pop     = 1'b1;
                  hold_d  = mem_q[rd_ptr_q];
                  widx_d  = widx_q + 7'd1;
                  state_d = LOW;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign full  = (count_q == FULL_CNT);
   assign wr_en = push_q && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !pop)      count_d = count_q + CW'(1);
      else if (pop && !wr_en) count_d = count_q - CW'(1);
      if (push_q && !wr_en)   ovf_d = 1'b1;
   end

   always_comb begin
      opTxStream = '0;
      if (state_q != IDLE) begin
         opTxStream.Valid       = 1'b1;
         opTxStream.Source      = SRC_ADDR;
         opTxStream.Destination = DEST_ADDR;
         opTxStream.Length      = LEN_BYTES;
         if (state_q == LOW) begin
            opTxStream.Data = hold_q[7:0];
            opTxStream.SoP  = (widx_q == 7'd0);
         end else begin
            opTxStream.Data = hold_q[15:8];
            opTxStream.EoP  = last;
         end
      end
   end

   assign opFIFO_Size = count_q;
   assign opOverflow  = ovf_q;

   always_ff @(posedge ipClk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_word_q;
   end

   always_ff @(posedge ipClk) begin
      if (!ipReset) begin
         nib_q       <= 2'd0;
         part_q      <= '0;
         push_q      <= 1'b0;
         push_word_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         state_q     <= IDLE;
         widx_q      <= '0;
         hold_q      <= '0;
      end else begin
         nib_q       <= nib_d;
         part_q      <= part_d;
         push_q      <= push_d;
         push_word_q <= push_word_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         widx_q      <= widx_d;
         hold_q      <= hold_d;
      end
   end
endmodule

// File: tb/tb_qam_destreamer.sv
// Scoreboard bench for qam_destreamer: stimulus pushes expected bytes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_qam_destreamer;
   import qam_destreamer_pkg::*;

   localparam int         WPP   = 4;
   localparam int         DEPTH = 16;
   localparam int         TMO   = 40;
   localparam logic [7:0] LEN   = 8'(2 * WPP);
`ifdef QAM_SYMBOL_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic                     ipClk = 1'b0;
   logic                     ipReset = 1'b0;
   logic [3:0]               ipQAMBlock = 4'h0;
   logic                     ipQAMBlockValid = 1'b0;
   logic                     ipTxReady = 1'b0;
   UART_PACKET               opTxStream;
   logic [$clog2(DEPTH):0]   opFIFO_Size;
   logic                     opOverflow;

   always #5 ipClk = ~ipClk;

   qam_destreamer #(
      .SRC_ADDR(8'h10), .DEST_ADDR(8'h00), .WORDS_PER_PACKET(WPP),
      .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .ipClk(ipClk), .ipReset(ipReset), .ipQAMBlock(ipQAMBlock),
      .ipQAMBlockValid(ipQAMBlockValid), .opTxStream(opTxStream),
      .ipTxReady(ipTxReady), .opFIFO_Size(opFIFO_Size), .opOverflow(opOverflow)
   );

   typedef struct {
      logic [7:0] dat;
      logic       sop;
      logic       eop;
      logic       hi;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  log_q[$];
   logic [3:0]  part_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          pushed = 0;
   int          done = 0;
   int          wcount = 0;
   bit          rnd_rdy = 1'b0;
   logic [15:0] t1_w [4]   = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
   logic [7:0]  t1_ref [8] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every accepted byte and checks stall stability.
   exp_t       mon_e;
   UART_PACKET prev_pkt;
   bit         prev_stall = 1'b0;
   always @(negedge ipClk) begin
      if (!ipReset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) chk("hold_stable", opTxStream, prev_pkt);
         if (opTxStream.Valid && ipTxReady) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_byte: got %02h, no byte expected", opTxStream.Data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("tx_byte",
                   {opTxStream.Source, opTxStream.Destination, opTxStream.Length,
                    opTxStream.Data, opTxStream.SoP, opTxStream.EoP},
                   {8'h10, 8'h00, LEN, mon_e.dat, mon_e.sop, mon_e.eop});
               if (mon_e.hi) done++;
            end
            log_q.push_back(opTxStream.Data);
         end
         prev_stall = opTxStream.Valid && !ipTxReady;
         prev_pkt   = opTxStream;
      end
   end

   task automatic tick();
      if (rnd_rdy) ipTxReady = 1'($urandom_range(0, 1));
      @(posedge ipClk);
      #1;
      ipQAMBlockValid = 1'b0;
   endtask

   task automatic push_word(input logic [15:0] w, input bit drop);
      int idx;
      if (drop) return;
      idx = wcount % WPP;
      exp_q.push_back('{dat: w[7:0],  sop: (idx == 0), eop: 1'b0,             hi: 1'b0});
      exp_q.push_back('{dat: w[15:8], sop: 1'b0,       eop: (idx == WPP - 1), hi: 1'b1});
      wcount++;
      pushed++;
   endtask

   task automatic send_nib(input logic [3:0] n, input bit drop);
      ipQAMBlock      = n;
      ipQAMBlockValid = 1'b1;
      part_q.push_back(n);
      tick();
      if (part_q.size() == 4) begin
         push_word({part_q[3], part_q[2], part_q[1], part_q[0]}, drop);
         part_q.delete();
      end
   endtask

   // With the transmitter stalled the block holds DEPTH words plus one in the output stage.
   task automatic send_word(input logic [15:0] w, input int gap, input bit stalled);
      bit drop;
      drop = stalled && ((pushed - done) >= DEPTH + 1);
      for (int k = 0; k < 4; k++) begin
         send_nib(w[4*k +: 4], drop);
         if (k < 3) repeat ($urandom_range(0, gap)) tick();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
      if (TMO_EN && n > TMO + 1) part_q.delete();
   endtask

   task automatic drain(input int left);
      int i = 0;
      while (exp_q.size() > left && i < 3000) begin
         tick();
         i++;
      end
      chk("drain_left", exp_q.size(), left);
      repeat (4) tick();
   endtask

   task automatic wait_valid();
      int i = 0;
      while (!opTxStream.Valid && i < 200) begin
         tick();
         i++;
      end
      chk("valid_up", opTxStream.Valid, 1'b1);
   endtask

   task automatic do_reset();
      ipReset         = 1'b0;
      ipQAMBlockValid = 1'b0;
      rnd_rdy         = 1'b0;
      ipTxReady       = 1'b0;
      exp_q.delete();
      part_q.delete();
      wcount = 0;
      pushed = done;
      tick();
      chk("rst_valid", opTxStream.Valid, 1'b0);
      chk("rst_size", opFIFO_Size, 0);
      tick();
      chk("rst_stream", opTxStream, 0);
      chk("rst_ovf", opOverflow, 1'b0);
      ipReset = 1'b1;
      tick();
   endtask

   task automatic pad_packet();
      while (part_q.size() != 0) send_nib(4'h0, 1'b0);
      while (wcount % WPP != 0) send_word(16'($urandom), 0, 1'b0);
   endtask

   initial begin
      @(posedge ipClk);
      #1;
      do_reset();

      // Basic packet
      log_q.delete();
      ipTxReady = 1'b1;
      for (int i = 0; i < 4; i++) send_word(t1_w[i], 0, 1'b0);
      drain(0);
      chk("t1_count", log_q.size(), 8);
      if (log_q.size() == 8)
         for (int i = 0; i < 8; i++) chk("t1_byte", log_q[i], t1_ref[i]);

      // Stall on the third byte
      log_q.delete();
      ipTxReady = 1'b0;
      for (int i = 0; i < 4; i++) send_word(t1_w[i], 0, 1'b0);
      wait_valid();
      ipTxReady = 1'b1;
      tick();
      tick();
      ipTxReady = 1'b0;
      repeat (5) tick();
      chk("t2_stall_data", {opTxStream.Valid, opTxStream.Data}, {1'b1, 8'h78});
      ipTxReady = 1'b1;
      drain(0);
      chk("t2_count", log_q.size(), 8);
      if (log_q.size() == 8)
         for (int i = 0; i < 8; i++) chk("t2_byte", log_q[i], t1_ref[i]);

      // Overflow while stalled
      do_reset();
      for (int i = 0; i < DEPTH + 2; i++) send_word(16'($urandom), 0, 1'b1);
      repeat (3) tick();
      chk("t3_size", opFIFO_Size, DEPTH);
      chk("t3_ovf", opOverflow, 1'b1);
      ipTxReady = 1'b1;
      drain(2);
      chk("t3_size_left", opFIFO_Size, 1);
      for (int i = 0; i < WPP - 1; i++) send_word(16'($urandom), 0, 1'b0);
      drain(0);
      chk("t3_ovf_sticky", opOverflow, 1'b1);

      // Push into a full FIFO on a pop cycle
      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) send_word(16'($urandom), 0, 1'b1);
      repeat (3) tick();
      chk("t5_full", opFIFO_Size, DEPTH);
      send_nib(4'h3, 1'b0);
      send_nib(4'hC, 1'b0);
      send_nib(4'h5, 1'b0);
      ipTxReady = 1'b1;
      send_nib(4'hA, 1'b0);
      tick();
      ipTxReady = 1'b0;
      repeat (2) tick();
      chk("t5_size", opFIFO_Size, DEPTH);
      chk("t5_ovf", opOverflow, 1'b0);
      ipTxReady = 1'b1;
      pad_packet();
      drain(0);
      chk("t5_ovf_end", opOverflow, 1'b0);

      // Reset mid-packet
      do_reset();
      log_q.delete();
      for (int i = 0; i < WPP; i++) send_word(16'($urandom), 0, 1'b0);
      wait_valid();
      ipTxReady = 1'b1;
      repeat (3) tick();
      ipTxReady = 1'b0;
      chk("t4_bytes", log_q.size(), 3);
      do_reset();
      ipTxReady = 1'b1;
      for (int i = 0; i < WPP; i++) send_word(16'($urandom), 0, 1'b0);
      drain(0);

      // Long silence inside a word
      do_reset();
      ipTxReady = 1'b1;
      send_nib(4'h1, 1'b0);
      send_nib(4'h2, 1'b0);
      idle(3 * TMO);
      send_nib(4'h4, 1'b0);
      send_nib(4'h3, 1'b0);
      send_nib(4'h2, 1'b0);
      send_nib(4'h1, 1'b0);
      pad_packet();
      drain(0);

      // Random traffic with random backpressure
      do_reset();
      rnd_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         int j = 0;
         while ((pushed - done) >= DEPTH && j < 500) begin
            tick();
            j++;
         end
         chk("throttle", ((pushed - done) < DEPTH), 1'b1);
         send_word(16'($urandom), 3, 1'b0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
      end
      pad_packet();
      drain(0);
      rnd_rdy   = 1'b0;
      ipTxReady = 1'b1;
      chk("rnd_ovf", opOverflow, 1'b0);
      chk("rnd_size", opFIFO_Size, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
